// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared 8-bit ALU: arbitrates, holds operands
// for one execute cycle, then registers the result until the consumer takes it.
module alu_arbiter #(
    parameter int unsigned FAIR = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req0_s,
    input  logic [2:0] req1_s,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_s,
    input  logic [7:0] alu_f,
    input  logic       alu_ovf,
    input  logic       alu_take_branch,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_id,
    output logic [7:0] resp_f,
    output logic       resp_ovf,
    output logic       resp_branch,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic       id_q, id_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [2:0] s_q, s_d;
    logic [7:0] f_q, f_d;
    logic       ovf_q, ovf_d;
    logic       br_q, br_d;
    logic       grant;

    // Winner id when in IDLE; on a tie the fair mode picks whoever was not served last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = (FAIR != 0) ? ~last_q : 1'b0;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        s_d        = s_q;
        f_d        = f_q;
        ovf_d      = ovf_q;
        br_d       = br_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = req0_valid & ~grant;
                req1_ready = req1_valid & grant;
                if (req0_valid || req1_valid) begin
                    state_d = EXEC;
                    id_d    = grant;
                    a_d     = grant ? req1_a : req0_a;
                    b_d     = grant ? req1_b : req0_b;
                    s_d     = grant ? req1_s : req0_s;
                end
            end
            EXEC: begin
                f_d     = alu_f;
                ovf_d   = alu_ovf;
                br_d    = alu_take_branch;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    last_d  = id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            f_q     <= '0;
            ovf_q   <= 1'b0;
            br_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            f_q     <= f_d;
            ovf_q   <= ovf_d;
            br_q    <= br_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign resp_valid  = (state_q == RESP);
    assign alu_a       = busy ? a_q : '0;
    assign alu_b       = busy ? b_q : '0;
    assign alu_s       = busy ? s_q : '0;
    assign resp_id     = id_q;
    assign resp_f      = f_q;
    assign resp_ovf    = ovf_q;
    assign resp_branch = br_q;

endmodule
